counter: RTL and testbench



---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_t_ff.sv | 29 ++
 rtl/counter.sv | 49 ++++
 tb/tb_counter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// ============================================================================
//  Module   : counter_pkg
//  Purpose  : Shared constants for the counters library.
//  Contents : COUNTER_WIDTH - default counter width in bits.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

   localparam int COUNTER_WIDTH = 3;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/counter_t_ff.sv
// ============================================================================
//  Module   : t_ff
//  Purpose  : Single toggle flip-flop with asynchronous active-low clear.
//  Ports    : clk - rising-edge clock
//             res - asynchronous clear, active-low
//             t   - toggle enable; q inverts on the edge when t=1
//             q   - registered state
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module t_ff (
   input  logic clk,
   input  logic res,
   input  logic t,
   output logic q
);

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         q <= 1'b0;
      end else if (t) begin
         q <= ~q;
      end
   end

endmodule : t_ff

`default_nettype wire

// File: rtl/counter.sv
// ============================================================================
//  Module   : counter
//  Purpose  : Free-running synchronous binary up-counter, wraps modulo
//             2^WIDTH, built from WIDTH toggle flip-flops on one clock.
//  Params   : WIDTH - counter width in bits (>= 1)
//  Ports    : clk   - sole clock, counts rising edges
//             res   - asynchronous clear, active-low
//             count - current value, driven straight from the flip-flops
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter
   import counter_pkg::*;
#(
   parameter int WIDTH = COUNTER_WIDTH
) (
   input  logic             clk,
   input  logic             res,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] q;

   // Bit i toggles only when every lower bit is 1 - the carry of a +1 add
   // expressed as an AND chain, so the result equals a binary increment.
   always_comb begin
      t    = '0;
      t[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         t[i] = t[i-1] & q[i-1];
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      t_ff u_t_ff (
         .clk (clk),
         .res (res),
         .t   (t[i]),
         .q   (q[i])
      );
   end

   assign count = q;

endmodule : counter

`default_nettype wire

// File: tb/tb_counter.sv
// ============================================================================
//  Module   : tb_counter
//  Purpose  : Self-checking bench for counter, run at WIDTH=3 and WIDTH=4
//             side by side on a shared clock and reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter;

   logic       clk = 1'b0;
   logic       res;
   logic [2:0] count3;
   logic [3:0] count4;

   typedef struct {
      logic [31:0] e3;
      logic [31:0] e4;
      logic        t3;   // expected toggle of bit 3 on the 4-bit counter
   } exp_t;

   exp_t        sb[$];
   int unsigned m3;
   int unsigned m4;
   int          n_checks = 0;
   int          n_fail   = 0;

   counter #(.WIDTH(3)) u_dut3 (
      .clk   (clk),
      .res   (res),
      .count (count3)
   );

   counter #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .res   (res),
      .count (count4)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Predict the next value, push it, let one edge happen, then pop and compare.
   task automatic step(input string tag);
      exp_t e;
      e.t3 = (m4 == 7) || (m4 == 15);
      m3   = (m3 + 1) % 8;
      m4   = (m4 + 1) % 16;
      e.e3 = m3;
      e.e4 = m4;
      sb.push_back(e);
      begin
         logic b3_prev;
         b3_prev = count4[3];
         @(posedge clk);
         #1;
         e = sb.pop_front();
         check({tag, "_w3"}, {29'b0, count3}, e.e3);
         check({tag, "_w4"}, {28'b0, count4}, e.e4);
         check({tag, "_b3tog"}, {31'b0, count4[3] ^ b3_prev}, {31'b0, e.t3});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      res = 1'b0;
      m3  = 0;
      m4  = 0;

      // Reset held across a rising edge: both counters stay 0
      @(posedge clk);
      #1;
      check("reset_w3", {29'b0, count3}, 32'd0);
      check("reset_w4", {28'b0, count4}, 32'd0);

      // Release away from the rising edge
      @(negedge clk);
      res = 1'b1;

      // First 8 edges: 1..7, 0 on the 3-bit counter
      for (int i = 0; i < 8; i++) step("wrap8");
      // Up to 20 edges total
      for (int i = 0; i < 12; i++) step("run");
      check("run20_w3", {29'b0, count3}, 32'd20 % 32'd8);
      // Up to 32 edges: 4-bit counter passes 7->8 and 15->0
      for (int i = 0; i < 12; i++) step("run4");
      check("run32_w4", {28'b0, count4}, 32'd0);

      // Mid-count reset between edges
      while (m3 != 5) step("to5");
      @(negedge clk);
      #2;
      res = 1'b0;
      #1;
      check("async_clr_w3", {29'b0, count3}, 32'd0);
      check("async_clr_w4", {28'b0, count4}, 32'd0);
      m3 = 0;
      m4 = 0;
      @(posedge clk);
      #1;
      check("hold_clr_w3", {29'b0, count3}, 32'd0);
      check("hold_clr_w4", {28'b0, count4}, 32'd0);
      @(negedge clk);
      res = 1'b1;
      for (int i = 0; i < 3; i++) step("resume");

      // Short reset pulse within one clock phase
      @(negedge clk);
      #1;
      res = 1'b0;
      #1;
      res = 1'b1;
      #1;
      check("pulse_clr_w3", {29'b0, count3}, 32'd0);
      check("pulse_clr_w4", {28'b0, count4}, 32'd0);
      m3 = 0;
      m4 = 0;
      for (int i = 0; i < 2; i++) step("after_pulse");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_counter

`default_nettype wire
